// File: rtl/alu_seq.sv
// Sequential execute-stage ALU: registered result behind valid/ready handshakes, iterative shifter.
// Define ALU_SEQ_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLT   = 4'd2;
  localparam logic [3:0] OP_SLTU  = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_PASSA = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;

  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  logic [0:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [1:0]       kind_q, kind_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic [1:0]       op_kind;
  logic             accept;
  logic             go_shift;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] step;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                  input logic [1:0]       k);
    logic [WIDTH-1:0] r;
    case (k)
      K_SLL:   r = {v[WIDTH-2:0], 1'b0};
      K_SRL:   r = {1'b0, v[WIDTH-1:1]};
      default: r = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

`ifdef ALU_SEQ_FAST_SHIFT_EN
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] v,
                                              input logic [1:0]       k,
                                              input logic [SHW-1:0]   n);
    logic signed [WIDTH-1:0] sv;
    logic [WIDTH-1:0]        r;
    sv = v;
    case (k)
      K_SLL:   r = v << n;
      K_SRL:   r = v >> n;
      default: r = sv >>> n;
    endcase
    return r;
  endfunction
`endif

  assign a_s      = A;
  assign b_s      = B;
  assign shamt    = B[SHW-1:0];
  assign is_shift = (OP == OP_SLL) || (OP == OP_SRL) || (OP == OP_SRA);
  assign op_kind  = (OP == OP_SLL) ? K_SLL : (OP == OP_SRL) ? K_SRL : K_SRA;

  // Accepting needs an idle FSM and an output register that is empty or draining now
  assign IN_READY = (state_q == S_IDLE) && (!out_valid_q || OUT_READY);
  assign accept   = IN_VALID && IN_READY;

`ifdef ALU_SEQ_FAST_SHIFT_EN
  assign go_shift = 1'b0;
  assign BUSY     = 1'b0;
`else
  assign go_shift = is_shift && (shamt != '0);
  assign BUSY     = (state_q == S_SHIFT);
`endif

  always_comb begin
    alu_res = '0;
    case (OP)
      OP_ADD:   alu_res = A + B;
      OP_SUB:   alu_res = A - B;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_AND:   alu_res = A & B;
      OP_OR:    alu_res = A | B;
      OP_XOR:   alu_res = A ^ B;
`ifdef ALU_SEQ_FAST_SHIFT_EN
      OP_SLL, OP_SRL, OP_SRA: alu_res = barrel(A, op_kind, shamt);
`else
      // Only reached with a zero amount; nonzero amounts go through the SHIFT state
      OP_SLL, OP_SRL, OP_SRA: alu_res = A;
`endif
      OP_PASSA: alu_res = A;
      OP_PASSB: alu_res = B;
      default:  alu_res = '0;
    endcase
  end

  assign step = shift_step(sh_q, kind_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    kind_d      = kind_q;
    out_valid_d = out_valid_q && !OUT_READY;
    result_d    = result_q;
    zero_d      = zero_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (go_shift) begin
            state_d = S_SHIFT;
            sh_d    = A;
            cnt_d   = shamt;
            kind_d  = op_kind;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        sh_d  = step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          result_d    = step;
          zero_d      = (step == '0);
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      kind_q      <= K_SLL;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      kind_q      <= kind_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign RESULT    = result_q;
  assign ZERO      = zero_q;

endmodule
